// File: rtl/wb_burst_data_mem.sv
// wb_burst_data_mem: Wishbone B4 data-memory slave for the core data bus.
// Programmable wait states before the first beat, err_o for accesses outside
// the mapped window, and incrementing bursts (CTI 3'b010) with one beat per cycle.
module wb_burst_data_mem #(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic [31:0]         adr_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic [2:0]          cti_i,
  output logic [DATA_W-1:0]   dat_o,
  output logic                ack_o,
  output logic                err_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  // The beat counter keeps the full word index so out-of-range beats stay detectable.
  localparam int CW    = 32 - LSB;
  localparam logic [CW-1:0] DEPTH_W   = CW'(DEPTH);
  localparam logic [1:0]    WAIT_INIT = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
  localparam logic [2:0]    CTI_INCR  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [1:0]        wcnt, wcnt_d;
  logic              ack_d, err_d;
  logic [DATA_W-1:0] dat_d;
  logic              acc;
  logic [31:0]       off;
  logic [CW-1:0]     widx;
  logic              load_rsp;
  logic [CW-1:0]     rsp_idx;
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] fwd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  assign acc     = cyc_i & stb_i;
  assign off     = adr_i - BASE_ADDR;
  assign widx    = CW'(off >> LSB);
  assign rd_word = mem[rsp_idx[AW-1:0]];

  // Next-state logic: picks the beat whose response is registered next and
  // decides whether the current beat commits a write.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    wcnt_d   = wcnt;
    load_rsp = 1'b0;
    rsp_idx  = cnt;
    mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          cnt_d = widx;
          if (WAIT_STATES == 0) begin
            state_d  = RESP;
            load_rsp = 1'b1;
            rsp_idx  = widx;
          end else begin
            state_d = WAIT;
            wcnt_d  = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (!acc) begin
          state_d = IDLE;
        end else if (wcnt == 2'd0) begin
          state_d  = RESP;
          load_rsp = 1'b1;
        end else begin
          wcnt_d = wcnt - 2'd1;
        end
      end
      RESP: begin
        mem_we = ack_o & acc & we_i;
        // An err beat always ends the transaction, even mid-burst.
        if (acc && ack_o && (cti_i == CTI_INCR)) begin
          cnt_d    = cnt + CW'(1);
          rsp_idx  = cnt + CW'(1);
          load_rsp = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response datapath: ack with memory data (forwarding a same-cycle write) or err with zero.
  always_comb begin
    fwd_word = rd_word;
    if (mem_we && (rsp_idx == cnt)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (sel_i[b]) fwd_word[8*b +: 8] = dat_i[8*b +: 8];
      end
    end
    ack_d = 1'b0;
    err_d = 1'b0;
    dat_d = dat_o;
    if (load_rsp) begin
      if (rsp_idx < DEPTH_W) begin
        ack_d = 1'b1;
        dat_d = fwd_word;
      end else begin
        err_d = 1'b1;
        dat_d = '0;
      end
    end
  end

  // State and registered bus outputs; reset drops ack/err immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      wcnt  <= '0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      wcnt  <= wcnt_d;
      ack_o <= ack_d;
      err_o <= err_d;
      dat_o <= dat_d;
    end
  end

  // Byte-lane writes; storage is deliberately left untouched by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (sel_i[b]) mem[cnt[AW-1:0]][8*b +: 8] <= dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_data_mem.sv
// tb_wb_burst_data_mem: directed and randomized checks of wb_burst_data_mem.
// Four instances (1, 0, 3 wait states at 32 bits; 1 wait state at 64 bits)
// share one bus; cyc_i is steered to the instance selected by tgt.
module tb_wb_burst_data_mem;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [7:0]  sel;
  logic [63:0] dat;
  logic [2:0]  cti;
  int          tgt;
  logic [3:0]  ack_v, err_v;
  logic [31:0] dat_a, dat_b, dat_c;
  logic [63:0] dat_d;

  int          nCompared   = 0;
  int          nMismatched = 0;
  logic [63:0] model [4][1024];
  logic [63:0] bdat [16];
  int          cycles, pick, len, start;
  logic [31:0] ra;

  always #5 clk = ~clk;

  wb_burst_data_mem #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(1), .BASE_ADDR(BASE)) dut_a (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc && (tgt == 0)), .stb_i(stb), .adr_i(adr), .we_i(we),
    .sel_i(sel[3:0]), .dat_i(dat[31:0]), .cti_i(cti), .dat_o(dat_a), .ack_o(ack_v[0]), .err_o(err_v[0]));

  wb_burst_data_mem #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut_b (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc && (tgt == 1)), .stb_i(stb), .adr_i(adr), .we_i(we),
    .sel_i(sel[3:0]), .dat_i(dat[31:0]), .cti_i(cti), .dat_o(dat_b), .ack_o(ack_v[1]), .err_o(err_v[1]));

  wb_burst_data_mem #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(3), .BASE_ADDR(BASE)) dut_c (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc && (tgt == 2)), .stb_i(stb), .adr_i(adr), .we_i(we),
    .sel_i(sel[3:0]), .dat_i(dat[31:0]), .cti_i(cti), .dat_o(dat_c), .ack_o(ack_v[2]), .err_o(err_v[2]));

  wb_burst_data_mem #(.DATA_W(64), .DEPTH(512), .WAIT_STATES(1), .BASE_ADDR(BASE)) dut_d (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc && (tgt == 3)), .stb_i(stb), .adr_i(adr), .we_i(we),
    .sel_i(sel), .dat_i(dat), .cti_i(cti), .dat_o(dat_d), .ack_o(ack_v[3]), .err_o(err_v[3]));

  // Per-instance configuration as seen by the reference model.
  function automatic int wsOf(input int k);
    return (k == 1) ? 0 : ((k == 2) ? 3 : 1);
  endfunction

  function automatic int bytesOf(input int k);
    return (k == 3) ? 8 : 4;
  endfunction

  function automatic int depthOf(input int k);
    return (k == 3) ? 512 : 1024;
  endfunction

  function automatic logic [63:0] datOf(input int k);
    case (k)
      0:       return {32'h0, dat_a};
      1:       return {32'h0, dat_b};
      2:       return {32'h0, dat_c};
      default: return dat_d;
    endcase
  endfunction

  // Response code: 1 = ack, 2 = err, 3 = both (illegal), 0 = none.
  function automatic logic [63:0] respOf(input int k);
    return {62'h0, err_v[k], ack_v[k]};
  endfunction

  // Word index of a byte address, or -1 when outside the mapped window.
  function automatic int idxOf(input int k, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 32'(depthOf(k) * bytesOf(k))) return -1;
    return int'(off) / bytesOf(k);
  endfunction

  function automatic logic [63:0] expWord(input int k, input int idx);
    logic [63:0] w;
    w = model[k][idx];
    if (bytesOf(k) == 4) w[63:32] = 32'h0;
    return w;
  endfunction

  function automatic logic [63:0] mergeLanes(input logic [63:0] old, input logic [63:0] nw,
                                             input logic [7:0] s, input int nb);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < nb; b++) begin
      if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ack or err from instance k; samples 1 time unit after each edge.
  task automatic waitResp(input int k, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((respOf(k) == 64'h0) && (n < 16));
  endtask

  // One classic transaction, checked against the reference model.
  task automatic applyStimulus(input int k, input logic [31:0] a, input logic w,
                               input logic [7:0] s, input logic [63:0] d, input string tag);
    int          idx, n;
    logic [63:0] expResp, expDat;
    idx     = idxOf(k, a);
    expResp = (idx >= 0) ? 64'd1 : 64'd2;
    expDat  = (idx >= 0) ? expWord(k, idx) : 64'h0;
    tgt = k; cyc = 1'b1; stb = 1'b1; adr = a; we = w; sel = s; dat = d; cti = 3'b000;
    waitResp(k, n);
    checkOutput({tag, "_lat"}, 64'(n), 64'(wsOf(k) + 1));
    checkOutput({tag, "_resp"}, respOf(k), expResp);
    if (!w || idx < 0) checkOutput({tag, "_dat"}, datOf(k), expDat);
    @(posedge clk);
    #1;
    checkOutput({tag, "_pulse"}, respOf(k), 64'h0);
    if (!w || idx < 0) checkOutput({tag, "_hold"}, datOf(k), expDat);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (w && idx >= 0) model[k][idx] = mergeLanes(model[k][idx], d, s, bytesOf(k));
  endtask

  // Incrementing burst of n beats (data from bdat), full byte lanes.
  task automatic applyBurst(input int k, input logic [31:0] a, input logic w,
                            input int n, input string tag);
    int          idx0, idx, nc;
    logic [63:0] expResp, obsResp;
    idx0 = idxOf(k, a);
    tgt = k; cyc = 1'b1; stb = 1'b1; adr = a; we = w; sel = 8'hFF; dat = bdat[0];
    cti = (n == 1) ? 3'b111 : 3'b010;
    waitResp(k, nc);
    checkOutput({tag, "_lat"}, 64'(nc), 64'(wsOf(k) + 1));
    for (int i = 0; i < n; i++) begin
      idx     = idx0 + i;
      expResp = (idx < depthOf(k)) ? 64'd1 : 64'd2;
      obsResp = respOf(k);
      checkOutput($sformatf("%s_beat%0d_resp", tag, i), obsResp, expResp);
      if (!w && expResp == 64'd1)
        checkOutput($sformatf("%s_beat%0d_dat", tag, i), datOf(k), expWord(k, idx));
      if (expResp == 64'd2)
        checkOutput($sformatf("%s_beat%0d_errdat", tag, i), datOf(k), 64'h0);
      if (w && expResp == 64'd1)
        model[k][idx] = mergeLanes(model[k][idx], bdat[i], 8'hFF, bytesOf(k));
      dat = bdat[i];
      cti = (i == n - 1) ? 3'b111 : 3'b010;
      adr = 32'hFFFF_FFF0;
      @(posedge clk);
      #1;
      if (obsResp != 64'd1 || expResp != 64'd1) break;
    end
    checkOutput({tag, "_idle"}, respOf(k), 64'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0; cti = '0; tgt = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_resp_a", respOf(0), 64'h0);
    checkOutput("rst_dat_a", datOf(0), 64'h0);
    checkOutput("rst_resp_d", respOf(3), 64'h0);
    checkOutput("rst_dat_d", datOf(3), 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] classic write/read with one wait state");
    applyStimulus(0, 32'h1008, 1'b1, 8'h0F, 64'hDEADBEEF, "a_wr");
    applyStimulus(0, 32'h1008, 1'b0, 8'h0F, 64'h0, "a_rd");
    checkOutput("a_rd_const", datOf(0), 64'hDEADBEEF);
    applyStimulus(0, 32'h100A, 1'b0, 8'h0F, 64'h0, "a_rd_lowbits");

    $display("[TB] byte lanes");
    applyStimulus(0, 32'h1010, 1'b1, 8'h0F, 64'hFFFFFFFF, "a_lane_fill");
    applyStimulus(0, 32'h1010, 1'b1, 8'h05, 64'h11223344, "a_lane_wr");
    applyStimulus(0, 32'h1010, 1'b0, 8'h0F, 64'h0, "a_lane_rd");
    checkOutput("a_lane_const", datOf(0), 64'hFF22FF44);

    $display("[TB] out-of-range access");
    applyStimulus(0, 32'h1000, 1'b1, 8'h0F, 64'hA5A5A5A5, "a_w0");
    applyStimulus(0, 32'h2000, 1'b1, 8'h0F, 64'h12345678, "a_oor_wr");
    applyStimulus(0, 32'h2000, 1'b0, 8'h0F, 64'h0, "a_oor_rd");
    applyStimulus(0, 32'h1000, 1'b0, 8'h0F, 64'h0, "a_r0");
    checkOutput("a_r0_const", datOf(0), 64'hA5A5A5A5);

    $display("[TB] bursts with zero wait states");
    for (int i = 0; i < 4; i++) bdat[i] = 64'(i + 1);
    applyBurst(1, 32'h1FF0, 1'b1, 4, "b_bwr");
    applyBurst(1, 32'h1FF0, 1'b0, 4, "b_brd");
    applyStimulus(1, 32'h1000, 1'b1, 8'h0F, 64'h0BADF00D, "b_w0");
    bdat[0] = 64'hAAAA0001; bdat[1] = 64'hBBBB0002; bdat[2] = 64'hCCCC0003;
    applyBurst(1, 32'h1FFC, 1'b1, 3, "b_top");
    applyStimulus(1, 32'h1000, 1'b0, 8'h0F, 64'h0, "b_r0");
    checkOutput("b_r0_const", datOf(1), 64'h0BADF00D);
    applyStimulus(1, 32'h1FFC, 1'b0, 8'h0F, 64'h0, "b_r1023");
    checkOutput("b_r1023_const", datOf(1), 64'hAAAA0001);

    $display("[TB] abort during wait states");
    applyStimulus(2, 32'h1004, 1'b1, 8'h0F, 64'h55, "c_wr");
    tgt = 2; cyc = 1'b1; stb = 1'b1; adr = 32'h1004; we = 1'b1; sel = 8'h0F; dat = 64'h77; cti = 3'b000;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("c_abort_wait", respOf(2), 64'h0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("c_abort_idle", respOf(2), 64'h0);
    we = 1'b0;
    applyStimulus(2, 32'h1004, 1'b0, 8'h0F, 64'h0, "c_rd");
    checkOutput("c_rd_const", datOf(2), 64'h55);

    $display("[TB] reset during a response cycle");
    applyStimulus(0, 32'h1004, 1'b1, 8'h0F, 64'h11111111, "a_pre");
    tgt = 0; cyc = 1'b1; stb = 1'b1; adr = 32'h1004; we = 1'b1; sel = 8'h0F; dat = 64'h99999999; cti = 3'b000;
    waitResp(0, cycles);
    checkOutput("a_rst_seen", respOf(0), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("a_rst_async", respOf(0), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 32'h1004, 1'b0, 8'h0F, 64'h0, "a_rst_rd");
    checkOutput("a_rst_const", datOf(0), 64'h11111111);

    $display("[TB] 64-bit instance");
    applyStimulus(3, 32'h1008, 1'b1, 8'hFF, 64'h0123456789ABCDEF, "d_wr");
    applyStimulus(3, 32'h1008, 1'b0, 8'hFF, 64'h0, "d_rd");
    checkOutput("d_rd_const", datOf(3), 64'h0123456789ABCDEF);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 16; i++) bdat[i] = {$urandom, $urandom};
    applyBurst(0, 32'h1040, 1'b1, 16, "a_rnd_init");
    for (int i = 0; i < 40; i++) begin
      pick = int'($urandom_range(0, 7));
      if (pick == 0)      ra = 32'h2000 + ($urandom_range(0, 15) << 2);
      else if (pick == 1) ra = 32'h0FFC;
      else                ra = 32'h1040 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      applyStimulus(0, ra, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)),
                    {32'h0, $urandom}, $sformatf("a_rnd%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      len   = int'($urandom_range(2, 6));
      start = int'($urandom_range(0, 16 - len));
      applyBurst(0, 32'h1040 + 32'(start * 4), 1'b0, len, $sformatf("a_rbrd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
